// File: rtl/lv_rac_arb_if.sv
// lv_rac_arb_if: requester / register-bank bundle around the register-access arbiter.
//   Requesters : OWT (0), SPI (1), WDG (2) level req + addr (+ wr/wdata for OWT/SPI),
//                one-cycle ack each, shared rdata/crc/err response.
//   Bank side  : req/wr/addr/wdata out, ack/rdata/crc in; o_tmo_err to the fault collector.
// slave modport = arbiter view, master modport = environment (requesters + bank) view.
interface lv_rac_arb_if #(
  parameter int REG_AW    = 7,
  parameter int REG_DW    = 8,
  parameter int REG_CRC_W = 8
);
  logic                 i_owt_rac_req, i_spi_rac_req, i_wdg_rac_req;
  logic                 i_owt_rac_wr, i_spi_rac_wr;
  logic [REG_AW-1:0]    i_owt_rac_addr, i_spi_rac_addr, i_wdg_rac_addr;
  logic [REG_DW-1:0]    i_owt_rac_wdata, i_spi_rac_wdata;
  logic                 o_rac_owt_ack, o_rac_spi_ack, o_rac_wdg_ack;
  logic [REG_DW-1:0]    o_rac_rdata;
  logic [REG_CRC_W-1:0] o_rac_crc;
  logic                 o_rac_err;
  logic                 o_bank_req, o_bank_wr;
  logic [REG_AW-1:0]    o_bank_addr;
  logic [REG_DW-1:0]    o_bank_wdata;
  logic                 i_bank_ack;
  logic [REG_DW-1:0]    i_bank_rdata;
  logic [REG_CRC_W-1:0] i_bank_crc;
  logic                 o_tmo_err;

  modport slave (
    input  i_owt_rac_req, i_spi_rac_req, i_wdg_rac_req, i_owt_rac_wr, i_spi_rac_wr,
           i_owt_rac_addr, i_spi_rac_addr, i_wdg_rac_addr, i_owt_rac_wdata, i_spi_rac_wdata,
           i_bank_ack, i_bank_rdata, i_bank_crc,
    output o_rac_owt_ack, o_rac_spi_ack, o_rac_wdg_ack, o_rac_rdata, o_rac_crc, o_rac_err,
           o_bank_req, o_bank_wr, o_bank_addr, o_bank_wdata, o_tmo_err
  );

  modport master (
    output i_owt_rac_req, i_spi_rac_req, i_wdg_rac_req, i_owt_rac_wr, i_spi_rac_wr,
           i_owt_rac_addr, i_spi_rac_addr, i_wdg_rac_addr, i_owt_rac_wdata, i_spi_rac_wdata,
           i_bank_ack, i_bank_rdata, i_bank_crc,
    input  o_rac_owt_ack, o_rac_spi_ack, o_rac_wdg_ack, o_rac_rdata, o_rac_crc, o_rac_err,
           o_bank_req, o_bank_wr, o_bank_addr, o_bank_wdata, o_tmo_err
  );
endinterface

// File: rtl/lv_rac_arb.sv
// lv_rac_arb: round-robin arbiter sharing the register-bank port among OWT, SPI and WDG.
//   i_clk  : system clock
//   i_rst  : synchronous active-high reset
//   rac    : lv_rac_arb_if.slave -- requester handshakes, shared response bus, bank port,
//            and the o_tmo_err timeout pulse.
// One transaction at a time: IDLE arbitrates, ISSUE holds the bank request until the bank
// acks or the timeout expires, DONE is a one-cycle guard so a requester's registered req
// drop is never mistaken for a new request.
module lv_rac_arb #(
  parameter int REG_AW      = 7,
  parameter int REG_DW      = 8,
  parameter int REG_CRC_W   = 8,
  parameter int ACK_TMO_CYC = 16
) (
  input logic         i_clk,
  input logic         i_rst,
  lv_rac_arb_if.slave rac
);
  localparam int NREQ = 3;
  localparam logic [7:0] TMO_LAST = 8'(ACK_TMO_CYC - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DONE} state_e;

  // requester index 0=OWT, 1=SPI, 2=WDG; WDG is read-only
  logic [NREQ-1:0]             req_vec, wr_vec;
  logic [NREQ-1:0][REG_AW-1:0] addr_vec;
  logic [NREQ-1:0][REG_DW-1:0] wdata_vec;

  assign req_vec   = {rac.i_wdg_rac_req, rac.i_spi_rac_req, rac.i_owt_rac_req};
  assign wr_vec    = {1'b0, rac.i_spi_rac_wr, rac.i_owt_rac_wr};
  assign addr_vec  = {rac.i_wdg_rac_addr, rac.i_spi_rac_addr, rac.i_owt_rac_addr};
  assign wdata_vec = {REG_DW'(0), rac.i_spi_rac_wdata, rac.i_owt_rac_wdata};

  state_e               state_q, state_d;
  logic [1:0]           last_grant_q, last_grant_d, grant_q, grant_d;
  logic [7:0]           tmo_cnt_q, tmo_cnt_d;
  logic                 bank_req_q, bank_req_d, bank_wr_q, bank_wr_d;
  logic [REG_AW-1:0]    bank_addr_q, bank_addr_d;
  logic [REG_DW-1:0]    bank_wdata_q, bank_wdata_d;
  logic [NREQ-1:0]      ack_q, ack_d;
  logic [REG_DW-1:0]    rdata_q, rdata_d;
  logic [REG_CRC_W-1:0] crc_q, crc_d;
  logic                 err_q, err_d, tmo_err_q, tmo_err_d;

  // round-robin pick: first requester found scanning from last_grant+1 (mod 3)
  logic [1:0] win;
  logic       win_vld;
  logic [2:0] cand;
  always_comb begin
    win     = 2'd0;
    win_vld = 1'b0;
    cand    = 3'd0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, last_grant_q} + 3'd1 + 3'(k);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (!win_vld && req_vec[cand[1:0]]) begin
        win     = cand[1:0];
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    tmo_cnt_d    = tmo_cnt_q;
    bank_req_d   = bank_req_q;
    bank_wr_d    = bank_wr_q;
    bank_addr_d  = bank_addr_q;
    bank_wdata_d = bank_wdata_q;
    rdata_d      = rdata_q;
    crc_d        = crc_q;
    ack_d        = '0;
    err_d        = 1'b0;
    tmo_err_d    = 1'b0;
    case (state_q)
      ST_IDLE: if (win_vld) begin
        state_d      = ST_ISSUE;
        grant_d      = win;
        last_grant_d = win;
        tmo_cnt_d    = '0;
        bank_req_d   = 1'b1;
        bank_wr_d    = wr_vec[win];
        bank_addr_d  = addr_vec[win];
        bank_wdata_d = wdata_vec[win];
      end
      ST_ISSUE: begin
        tmo_cnt_d = tmo_cnt_q + 8'd1;
        // ack is checked first so an ack on the terminal count still completes normally
        if (rac.i_bank_ack) begin
          rdata_d          = rac.i_bank_rdata;
          crc_d            = rac.i_bank_crc;
          ack_d[grant_q]   = 1'b1;
          bank_req_d       = 1'b0;
          bank_wr_d        = 1'b0;
          tmo_cnt_d        = '0;
          state_d          = ST_DONE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          rdata_d          = '0;
          crc_d            = '0;
          err_d            = 1'b1;
          tmo_err_d        = 1'b1;
          ack_d[grant_q]   = 1'b1;
          bank_req_d       = 1'b0;
          bank_wr_d        = 1'b0;
          tmo_cnt_d        = '0;
          state_d          = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 2'd2;
      grant_q      <= 2'd0;
      tmo_cnt_q    <= '0;
      bank_req_q   <= 1'b0;
      bank_wr_q    <= 1'b0;
      bank_addr_q  <= '0;
      bank_wdata_q <= '0;
      ack_q        <= '0;
      rdata_q      <= '0;
      crc_q        <= '0;
      err_q        <= 1'b0;
      tmo_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      tmo_cnt_q    <= tmo_cnt_d;
      bank_req_q   <= bank_req_d;
      bank_wr_q    <= bank_wr_d;
      bank_addr_q  <= bank_addr_d;
      bank_wdata_q <= bank_wdata_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      crc_q        <= crc_d;
      err_q        <= err_d;
      tmo_err_q    <= tmo_err_d;
    end
  end

  assign rac.o_rac_owt_ack = ack_q[0];
  assign rac.o_rac_spi_ack = ack_q[1];
  assign rac.o_rac_wdg_ack = ack_q[2];
  assign rac.o_rac_rdata   = rdata_q;
  assign rac.o_rac_crc     = crc_q;
  assign rac.o_rac_err     = err_q;
  assign rac.o_bank_req    = bank_req_q;
  assign rac.o_bank_wr     = bank_wr_q;
  assign rac.o_bank_addr   = bank_addr_q;
  assign rac.o_bank_wdata  = bank_wdata_q;
  assign rac.o_tmo_err     = tmo_err_q;
endmodule
